// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART transmit scheduler: FSM
//               state encoding, frame-length helper and default line timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Default line timing: 100 MHz system clock at 9600 baud, 8N1 framing
  localparam int DEF_CLKS_PER_BIT = 10417;
  localparam int DEF_FRAME_BITS   = 10;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  // Number of clock cycles one complete frame occupies on the line
  function automatic int frame_cycles(input int clks_per_bit, input int frame_bits);
    return clks_per_bit * frame_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Picks the first asserted
//               request searching upward from ptr with wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  // One extra bit so ptr + offset never overflows before the wrap correction
  logic [IDX_W:0] cand;
  logic           found;

  // Scan NUM_REQ candidates starting at ptr; the first asserted request wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    if (enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, ptr} + (IDX_W+1)'(k);
        if (cand >= (IDX_W+1)'(NUM_REQ)) begin
          cand = cand - (IDX_W+1)'(NUM_REQ);
        end
        if (!found && req[cand[IDX_W-1:0]]) begin
          found                      = 1'b1;
          grant[cand[IDX_W-1:0]]     = 1'b1;
          grant_idx                  = cand[IDX_W-1:0];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// Module      : uart_tx_scheduler
// Description : Shares one byte-wide UART transmitter among NUM_REQ byte
//               sources. Round-robin grants one byte at a time, strobes the
//               transmitter and times the frame plus an idle gap itself,
//               since the transmitter has no busy output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FRAME_BITS   = DEF_FRAME_BITS,
  parameter int GAP_CYCLES   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_transmit,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       frame_done
);

  localparam int IDX_W        = $clog2(NUM_REQ);
  localparam int FRAME_CYCLES = frame_cycles(CLKS_PER_BIT, FRAME_BITS);
  localparam int CNT_W        = $clog2(FRAME_CYCLES + GAP_CYCLES + 1);
  localparam bit HAS_GAP      = (GAP_CYCLES > 0);

  localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = HAS_GAP ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] rr_ptr;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_en;
  logic             cnt_zero;
  logic             granted;

  // Grants are only possible in IDLE, and reset suppresses a same-cycle grant
  assign arb_en   = (state == ST_IDLE) && !rst;
  assign granted  = |arb_grant;
  assign cnt_zero = (cnt == '0);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .enable    (arb_en),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next-state logic: one cycle each of LOAD and SEND, then frame and gap timing
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (granted)  state_n = ST_LOAD;
      ST_LOAD:               state_n = ST_SEND;
      ST_SEND:               state_n = ST_WAIT;
      ST_WAIT: if (cnt_zero) state_n = HAS_GAP ? ST_GAP : ST_IDLE;
      ST_GAP:  if (cnt_zero) state_n = ST_IDLE;
      default:               state_n = ST_IDLE;
    endcase
  end

  // FSM outputs; frame_done is raised in the last cycle before IDLE is re-entered
  always_comb begin
    req_ready   = arb_grant;
    tx_transmit = (state == ST_SEND) && !rst;
    busy        = (state != ST_IDLE);
    frame_done  = !rst && cnt_zero &&
                  ((state == ST_GAP) || ((state == ST_WAIT) && !HAS_GAP));
  end

  // Datapath: byte capture, grant bookkeeping and the frame/gap down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rr_ptr   <= '0;
      tx_data  <= 8'h00;
      grant_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (granted) begin
            tx_data  <= req_data[{arb_idx, 3'b000} +: 8];
            grant_id <= arb_idx;
            rr_ptr   <= (arb_idx == LAST_IDX) ? '0 : arb_idx + IDX_W'(1);
          end
        end
        ST_SEND: cnt <= FRAME_LOAD;
        ST_WAIT: cnt <= cnt_zero ? GAP_LOAD : cnt - CNT_W'(1);
        ST_GAP:  if (!cnt_zero) cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
// Module      : tb_uart_tx_scheduler
// Description : Self-checking bench for uart_tx_scheduler with short line
//               timing (4 clocks/bit, 10 bits, 2 gap cycles).
//               Frame timeline from a grant in cycle G: LOAD G+1, SEND G+2,
//               WAIT G+3..G+42, GAP G+43..G+44 (frame_done at G+44),
//               earliest next grant G+45.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_scheduler;

  localparam int NUM_REQ = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_transmit;
  logic        busy;
  logic [1:0]  grant_id;
  logic        frame_done;

  int vectors     = 0;
  int miscompares = 0;

  uart_tx_scheduler #(
    .NUM_REQ      (NUM_REQ),
    .CLKS_PER_BIT (4),
    .FRAME_BITS   (10),
    .GAP_CYCLES   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_transmit (tx_transmit),
    .busy        (busy),
    .grant_id    (grant_id),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge (inputs are driven here)
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge of the current cycle (outputs are sampled here)
  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  exp_ready;
    logic [7:0]  exp_data;
    logic [1:0]  exp_gid;
  } vec_t;

  vec_t tv[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at;
    int ng;
    int last;
    bit pend;

    // Round-robin pointer evolution from reset (ptr=0), hand-derived
    tv[0] = '{4'b0010, 32'h0000_A500, 4'b0010, 8'hA5, 2'd1}; // ptr -> 2
    tv[1] = '{4'b1111, 32'h4433_2211, 4'b0100, 8'h33, 2'd2}; // ptr -> 3
    tv[2] = '{4'b0011, 32'h4433_2211, 4'b0001, 8'h11, 2'd0}; // 3 idle, wraps to 0; ptr -> 1
    tv[3] = '{4'b0001, 32'h4433_2211, 4'b0001, 8'h11, 2'd0}; // ptr -> 1
    tv[4] = '{4'b1000, 32'h4433_2211, 4'b1000, 8'h44, 2'd3}; // ptr wraps -> 0
    tv[5] = '{4'b1001, 32'h4433_2211, 4'b0001, 8'h11, 2'd0}; // ptr -> 1
    tv[6] = '{4'b0000, 32'h4433_2211, 4'b0000, 8'h11, 2'd0}; // no request: nothing changes
    tv[7] = '{4'b0110, 32'h4433_2211, 4'b0010, 8'h22, 2'd1}; // ptr -> 2

    // Reset values
    cyc();
    cyc();
    smp();
    chk("rst req_ready", req_ready, 4'b0000);
    chk("rst tx_data", tx_data, 8'h00);
    chk("rst tx_transmit", tx_transmit, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst grant_id", grant_id, 2'd0);
    chk("rst frame_done", frame_done, 1'b0);
    cyc();
    rst = 1'b0;

    // Table-driven single transactions, each followed by a complete frame
    for (int i = 0; i < 8; i++) begin
      req_valid = tv[i].valid;
      req_data  = tv[i].data;
      smp();
      chk("vec req_ready", req_ready, tv[i].exp_ready);
      chk("vec busy idle", busy, 1'b0);
      cyc();
      req_valid = '0;
      smp();
      chk("vec tx_data", tx_data, tv[i].exp_data);
      chk("vec grant_id", grant_id, tv[i].exp_gid);
      if (tv[i].exp_ready != 4'b0000) begin
        chk("vec busy load", busy, 1'b1);
        cyc();
        smp();
        chk("vec tx_transmit", tx_transmit, 1'b1);
        done_at = -1;
        for (int k = 1; k <= 60; k++) begin
          cyc();
          smp();
          if (frame_done) begin
            done_at = k;
            break;
          end
        end
        chk("vec frame_done delay", done_at, 42);
      end else begin
        chk("vec busy stays low", busy, 1'b0);
      end
      cyc();
    end

    // All requesters valid continuously after a reset: 0,1,2,3,0 every 45 cycles
    rst = 1'b1;
    req_valid = '0;
    cyc();
    rst = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'h4433_2211;
    ng = 0;
    last = 0;
    pend = 1'b0;
    for (int c = 0; c < 260 && ng < 5; c++) begin
      smp();
      if (pend) begin
        chk("rr tx_data", tx_data, 32'(((ng - 1) % 4 + 1) * 8'h11));
        chk("rr grant_id", grant_id, 32'((ng - 1) % 4));
        pend = 1'b0;
      end
      if (req_ready != 4'b0000) begin
        chk("rr grant", req_ready, 32'(1 << (ng % 4)));
        if (ng > 0) chk("rr spacing", c - last, 45);
        last = c;
        ng++;
        pend = 1'b1;
      end
      cyc();
    end
    chk("rr grant count", ng, 5);
    smp();
    if (pend) begin
      chk("rr tx_data last", tx_data, 8'h11);
    end

    // Reset pulse in the middle of WAIT
    req_valid = '0;
    for (int k = 0; k < 10; k++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    smp();
    chk("midrst busy", busy, 1'b0);
    chk("midrst tx_transmit", tx_transmit, 1'b0);
    chk("midrst req_ready", req_ready, 4'b0000);
    chk("midrst grant_id", grant_id, 2'd0);
    chk("midrst tx_data", tx_data, 8'h00);
    cyc();
    req_valid = 4'b1111;
    req_data  = 32'h3C00_005A;
    smp();
    chk("midrst first grant", req_ready, 4'b0001);

    // Data hold and mid-frame arrival: requester 3 rises during WAIT
    for (int c = 1; c <= 46; c++) begin
      cyc();
      if (c == 1)  req_valid = '0;
      if (c == 10) begin
        req_data  = 32'h3C00_00FF;
        req_valid = 4'b1000;
      end
      if (c == 46) req_valid = '0;
      smp();
      if (c <= 44) chk("mid req_ready held off", req_ready, 4'b0000);
      if (c <= 45) chk("hold tx_data", tx_data, 8'h5A);
      if (c == 2)  chk("hold tx_transmit", tx_transmit, 1'b1);
      if (c == 43) chk("hold frame_done early", frame_done, 1'b0);
      if (c == 44) chk("hold frame_done", frame_done, 1'b1);
      if (c == 45) chk("mid req_ready", req_ready, 4'b1000);
      if (c == 46) begin
        chk("mid tx_data", tx_data, 8'h3C);
        chk("mid grant_id", grant_id, 2'd3);
      end
    end

    // Request withdrawn during GAP is never granted
    for (int c = 2; c <= 50; c++) begin
      cyc();
      if (c == 43) req_valid = 4'b0100;
      if (c == 44) req_valid = 4'b0000;
      smp();
      chk("wd req_ready", req_ready, 4'b0000);
      if (c == 2)  chk("wd tx_transmit", tx_transmit, 1'b1);
      if (c == 44) chk("wd frame_done", frame_done, 1'b1);
      if (c == 44) chk("wd busy gap", busy, 1'b1);
      if (c >= 45) chk("wd busy idle", busy, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
